// File: rtl/tof_pkg.sv
// Shared types and default timing constants for the ultrasonic time-of-flight controller.
package tof_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BURST,
    BLANK,
    LISTEN,
    DONE
  } tof_state_e;

  localparam int unsigned DEF_CNT_W          = 20;
  localparam int unsigned DEF_BURST_CYCLES   = 800;
  localparam int unsigned DEF_BLANK_CYCLES   = 4800;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 576000;
  localparam int unsigned DEF_DEB_LEN        = 3;

  // Cycles from the first edge sampling echo high to the qualified detect.
  function automatic int unsigned echo_lat(input int unsigned deb_len);
    return 2 + deb_len;
  endfunction

endpackage

// File: rtl/tof_capture_echo.sv
// echo_qualifier: 2-flop synchronizer plus saturating debounce; level and first-reach edge outputs.
module echo_qualifier #(
  parameter int unsigned DEB_LEN = 3
) (
  input  logic gclk,
  input  logic rstn,
  input  logic echo_i,
  output logic lvl_o,
  output logic det_o
);

  localparam int unsigned DEB_W = $clog2(DEB_LEN + 1);

  logic             sync1_q, sync2_q;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             det_q;

  always_comb begin
    deb_d = deb_q;
    if (!sync2_q)
      deb_d = '0;
    else if (deb_q < DEB_W'(DEB_LEN))
      deb_d = deb_q + 1'b1;
  end

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= '0;
      det_q   <= 1'b0;
    end else begin
      sync1_q <= echo_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      det_q   <= sync2_q && (deb_q == DEB_W'(DEB_LEN - 1));
    end
  end

  assign lvl_o = (deb_q == DEB_W'(DEB_LEN));
  assign det_o = det_q;

endmodule

// File: rtl/tof_capture.sv
// Ultrasonic ranging controller: burst, ring-down blank, then time the first qualified echo.
// Optional build macro TOF_LAT_COMP_EN removes the echo path latency from captured results.
module tof_capture
  import tof_pkg::*;
#(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned BURST_CYCLES   = DEF_BURST_CYCLES,
  parameter int unsigned BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned DEB_LEN        = DEF_DEB_LEN
) (
  input  logic             gclk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic             echo_in,
  output logic             burst_en,
  output logic             busy,
  output logic [CNT_W-1:0] tof,
  output logic             timeout,
  output logic             tof_valid
);

  localparam int unsigned ECHO_LAT = echo_lat(DEB_LEN);

  if (TIMEOUT_CYCLES >= (64'd1 << CNT_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be below 2**CNT_W");
  end

  tof_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tof_q, tof_d;
  logic [CNT_W-1:0] cap;
  logic             burst_q, burst_d;
  logic             to_q, to_d;
  logic             echo_lvl, echo_det;

  echo_qualifier #(.DEB_LEN(DEB_LEN)) u_echo (
    .gclk   (gclk),
    .rstn   (rstn),
    .echo_i (echo_in),
    .lvl_o  (echo_lvl),
    .det_o  (echo_det)
  );

`ifdef TOF_LAT_COMP_EN
  assign cap = (cnt_q >= CNT_W'(ECHO_LAT)) ? cnt_q - CNT_W'(ECHO_LAT) : '0;
`else
  assign cap = cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    tof_d   = tof_q;
    to_d    = to_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      burst_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_d = BURST;
          cnt_d   = '0;
          burst_d = 1'b1;
        end
        BURST: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BURST_CYCLES - 1)) begin
            state_d = BLANK;
            burst_d = 1'b0;
          end
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BURST_CYCLES + BLANK_CYCLES - 1))
            state_d = LISTEN;
        end
        LISTEN: begin
          cnt_d = cnt_q + 1'b1;
          // Level covers an echo already qualified during blanking; edge covers fresh ones.
          if (echo_lvl || echo_det) begin
            state_d = DONE;
            tof_d   = cap;
            to_d    = 1'b0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = DONE;
            tof_d   = CNT_W'(TIMEOUT_CYCLES);
            to_d    = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      burst_q <= 1'b0;
      tof_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      tof_q   <= tof_d;
      to_q    <= to_d;
    end
  end

  assign burst_en  = burst_q;
  assign busy      = (state_q != IDLE);
  assign tof       = tof_q;
  assign timeout   = to_q;
  assign tof_valid = (state_q == DONE);

endmodule

// File: tb/tb_tof_capture.sv
// Scoreboard bench for tof_capture with short sim timing; honours TOF_LAT_COMP_EN.
module tb_tof_capture;

  localparam int CNT_W   = 20;
  localparam int BURST   = 16;
  localparam int BLANK   = 32;
  localparam int TMO     = 200;
  localparam int DEB     = 3;
  localparam int LAT     = 2 + DEB;
  localparam int LISTEN0 = BURST + BLANK;

  typedef struct {
    logic [CNT_W-1:0] tof;
    logic             to;
  } res_t;

  logic             gclk, rstn, start, abort, echo_in;
  logic             burst_en, busy, timeout, tof_valid;
  logic [CNT_W-1:0] tof;

  res_t             sb_q[$];
  int               n_chk, n_pass;
  logic [CNT_W-1:0] last_tof;
  logic             last_to;

  tof_capture #(
    .CNT_W          (CNT_W),
    .BURST_CYCLES   (BURST),
    .BLANK_CYCLES   (BLANK),
    .TIMEOUT_CYCLES (TMO),
    .DEB_LEN        (DEB)
  ) dut (
    .gclk      (gclk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .echo_in   (echo_in),
    .burst_en  (burst_en),
    .busy      (busy),
    .tof       (tof),
    .timeout   (timeout),
    .tof_valid (tof_valid)
  );

  initial begin
    gclk = 1'b0;
    forever #5 gclk = ~gclk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  always @(negedge gclk) begin
    res_t r;
    if (rstn && tof_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexp_valid", 32'(tof_valid), 32'd0);
      end else begin
        r = sb_q.pop_front();
        chk("sb_tof", 32'(tof), 32'(r.tof));
        chk("sb_timeout", 32'(timeout), 32'(r.to));
        last_tof = r.tof;
        last_to  = r.to;
      end
    end
  end

  task automatic idle(input int n);
    start = 1'b0; abort = 1'b0; echo_in = 1'b0;
    repeat (n) @(negedge gclk);
  endtask

  // Echo high while cnt in [lo,hi]; extra start/abort/reset at the given cnt (-1 = none).
  task automatic run_meas(input int lo, input int hi, input int st2_at,
                          input int abort_at, input int rst_at);
    int   d, bursts, vcyc, exp_vcyc;
    bit   hit, done, clean;
    res_t e;
    d     = (lo + LAT > LISTEN0) ? lo + LAT : LISTEN0;
    hit   = (lo >= 0) && (hi >= d - LAT + DEB - 1) && (d < TMO);
    clean = (abort_at < 0) && (rst_at < 0);
    if (hit) begin
`ifdef TOF_LAT_COMP_EN
      e.tof = CNT_W'((d >= LAT) ? d - LAT : 0);
`else
      e.tof = CNT_W'(d);
`endif
      e.to     = 1'b0;
      exp_vcyc = d + 1;
    end else begin
      e.tof    = CNT_W'(TMO);
      e.to     = 1'b1;
      exp_vcyc = TMO;
    end
    if (clean) sb_q.push_back(e);

    @(negedge gclk); start = 1'b1;
    @(negedge gclk); start = 1'b0;
    bursts = 0; vcyc = -1; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      echo_in = (i >= lo) && (i <= hi);
      start   = (i == st2_at);
      abort   = (i == abort_at);
      if (burst_en) bursts++;
      if (tof_valid) begin vcyc = i; done = 1'b1; end
      if (abort_at >= 0 && i == abort_at + 1) begin
        chk("abort_burst", 32'(burst_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        done = 1'b1;
      end
      if (i == rst_at) begin
        #2 rstn = 1'b0;
        #1;
        chk("rst_burst", 32'(burst_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tof", 32'(tof), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_valid", 32'(tof_valid), 32'd0);
        chk("rst_bursts_seen", 32'(bursts), 32'((i < BURST) ? i + 1 : BURST));
        done = 1'b1;
      end
      @(negedge gclk);
    end
    start = 1'b0; abort = 1'b0; echo_in = 1'b0;
    chk("run_ended", 32'(done), 32'd1);
    if (rst_at >= 0) begin
      rstn = 1'b1;
      last_tof = '0;
      last_to  = 1'b0;
    end
    if (clean) begin
      chk("burst_len", 32'(bursts), 32'(BURST));
      chk("valid_cycle", 32'(vcyc), 32'(exp_vcyc));
      chk("busy_after", 32'(busy), 32'd0);
      chk("valid_one_cycle", 32'(tof_valid), 32'd0);
    end
    if (abort_at >= 0) begin
      idle(TMO + 20);
      chk("abort_tof_held", 32'(tof), 32'(last_tof));
      chk("abort_to_held", 32'(timeout), 32'(last_to));
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    last_tof = '0; last_to = 1'b0;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; echo_in = 1'b0;
    #12;
    chk("reset_burst", 32'(burst_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tof", 32'(tof), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_valid", 32'(tof_valid), 32'd0);
    @(negedge gclk); rstn = 1'b1;
    idle(3);

    run_meas(-1, -1, 5, -1, -1);   // no echo, second start in BURST ignored
    idle(5);
    run_meas(100, 999, -1, -1, -1);
    idle(5);
    run_meas(20, 40, -1, -1, -1);  // echo only inside blanking
    idle(5);
    run_meas(30, 999, -1, -1, -1); // echo spans LISTEN entry
    idle(5);
    run_meas(-1, -1, -1, 10, -1);  // abort in BURST
    idle(5);
    run_meas(60, 999, -1, -1, -1);
    idle(5);
    run_meas(150, 152, -1, -1, -1); // exactly DEB_LEN samples high
    idle(5);
    run_meas(150, 151, -1, -1, -1); // one sample short: timeout
    idle(5);
    run_meas(196, 999, -1, -1, -1); // echo lands after last count: timeout
    idle(5);
    run_meas(194, 999, -1, -1, -1); // detect on cnt 199 wins over timeout
    idle(5);
    run_meas(-1, -1, -1, -1, 8);   // reset during BURST
    idle(5);
    run_meas(55, 999, -1, -1, 60); // reset mid-LISTEN
    idle(5);
    run_meas(70, 999, -1, -1, -1);
    idle(5);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
